// File: rtl/clk_div_bank.sv
// clk_div_bank: N_CH independent, runtime-programmable clock-enable channels.
// Each channel produces a periodic one-cycle tick, a square wave, or a single one-shot pulse.
module clk_div_bank #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [1:0]       cfg_mode,
  input  logic             sync,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  sq_out,
  output logic [N_CH-1:0]  busy
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_TICK = 2'b01,
    MODE_SQ   = 2'b10,
    MODE_ONE  = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Terminal count De-1 without widening: div values 0 and 1 both mean De=1.
  function automatic logic [WIDTH-1:0] last_count(input logic [WIDTH-1:0] d);
    if (d == CNT_ZERO) begin
      last_count = CNT_ZERO;
    end else begin
      last_count = d - CNT_ONE;
    end
  endfunction

  // De>>1 equals div>>1 for every div, including the div=0 alias of De=1.
  function automatic logic [WIDTH-1:0] half_point(input logic [WIDTH-1:0] d);
    half_point = d >> 1;
  endfunction

  mode_t            mode_r    [N_CH];
  mode_t            mode_nx_s [N_CH];
  logic [WIDTH-1:0] div_r     [N_CH];
  logic [WIDTH-1:0] div_nx_s  [N_CH];
  logic [WIDTH-1:0] cnt_r     [N_CH];
  logic [WIDTH-1:0] cnt_nx_s  [N_CH];
  logic [N_CH-1:0]  term_s;
  logic [N_CH-1:0]  wr_hit_s;

  // Per-channel terminal-count and write-address decode.
  always_comb begin
    term_s   = {N_CH{1'b0}};
    wr_hit_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      term_s[i]   = (cnt_r[i] == last_count(div_r[i]));
      wr_hit_s[i] = cfg_wr && (cfg_ch == 4'(i));
    end
  end

  // Next-state: write beats sync; a one-shot terminal always retires even under sync.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      mode_nx_s[i] = mode_r[i];
      div_nx_s[i]  = div_r[i];
      cnt_nx_s[i]  = cnt_r[i];
      if (wr_hit_s[i]) begin
        mode_nx_s[i] = mode_t'(cfg_mode);
        div_nx_s[i]  = cfg_div;
        cnt_nx_s[i]  = CNT_ZERO;
      end else if (mode_r[i] == MODE_OFF) begin
        cnt_nx_s[i] = CNT_ZERO;
      end else begin
        if (term_s[i] && (mode_r[i] == MODE_ONE)) begin
          mode_nx_s[i] = MODE_OFF;
        end else begin
          mode_nx_s[i] = mode_r[i];
        end
        if (sync || term_s[i]) begin
          cnt_nx_s[i] = CNT_ZERO;
        end else begin
          cnt_nx_s[i] = cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        mode_r[i] <= MODE_OFF;
        div_r[i]  <= CNT_ONE;
        cnt_r[i]  <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        mode_r[i] <= mode_nx_s[i];
        div_r[i]  <= div_nx_s[i];
        cnt_r[i]  <= cnt_nx_s[i];
      end
    end
  end

  // Output decode from registered state only; no input reaches an output.
  always_comb begin
    tick   = {N_CH{1'b0}};
    sq_out = {N_CH{1'b0}};
    busy   = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      busy[i] = (mode_r[i] != MODE_OFF);
      case (mode_r[i])
        MODE_TICK: tick[i]   = term_s[i];
        MODE_ONE:  tick[i]   = term_s[i];
        MODE_SQ:   sq_out[i] = (cnt_r[i] >= half_point(div_r[i]));
        default: begin
          tick[i]   = 1'b0;
          sq_out[i] = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel, runtime-programmable clock-enable generator. It replaces fixed single-divisor derived clocks with N_CH independent channels in the `clk` domain. Each channel is configured over a simple write port and produces a one-cycle `tick` enable, a square-wave `sq_out`, or a single one-shot pulse. It sits beside `com_block` on `mclk` and feeds timers, UART baud enables and LED blink logic without creating new clock domains.

## Interface
- N_CH, 4, number of channels (1..16)
- WIDTH, 28, counter/divisor width in bits
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_wr  in  1  configuration write strobe, sampled on rising edge
- cfg_ch  in  4  target channel index; values >= N_CH are ignored
- cfg_div  in  WIDTH  divisor D for the target channel
- cfg_mode  in  2  00 off, 01 periodic tick, 10 square, 11 one-shot
- sync  in  1  phase-align: restart every running channel's counter
- tick  out  N_CH  per-channel one-cycle enable
- sq_out  out  N_CH  per-channel square wave
- busy  out  N_CH  channel running (mode != off)

## Operation
- Per-channel state: mode[1:0], div[WIDTH-1:0], cnt[WIDTH-1:0].
- Effective divisor De = (div == 0) ? 1 : div. All compares use De-1; no WIDTH+1 arithmetic.
- Write (cfg_wr=1, cfg_ch<N_CH): the addressed channel loads mode and div and sets cnt=0. Other channels are unaffected.
- Running channel: cnt increments each edge. When cnt==De-1 it wraps to 0 on the next edge.
- Off: cnt held at 0; tick=0, sq_out=0, busy=0.
- Periodic (01): tick = (cnt==De-1). Period is exactly De cycles. De=1 gives tick constantly high.
- Square (10): sq_out = (cnt >= De>>1).
  - Low for floor(De/2) cycles, then high for ceil(De/2) cycles.
  - De=1 gives constant high.
  - tick=0 in this mode.
- One-shot (11): tick = (cnt==De-1). On that same edge mode returns to 00, so exactly one pulse is produced. busy and tick are high together in the final cycle.
- sync=1: every channel with mode != 00 sets cnt=0. Mode and div are unchanged.
- Write and sync in the same cycle: the write applies to the addressed channel (cnt=0 either way); sync applies to all others.
- Write to a running channel: immediate restart with the new mode and div; no completion of the old period.
- Write of mode 00: the channel stops next cycle; a pending one-shot is cancelled without a pulse.

## Timing
- Reset: all mode=00, div=1, cnt=0.
- All outputs are 0 in the cycle after reset asserts. rst has priority over cfg_wr and sync.
- Outputs are decoded combinationally from registered state only, with no input-to-output path. Consumers sample them on `clk`.
- Write accepted at edge E0: busy=1 from E0.
  - First tick is high in the cycle starting at edge E0+De-1.
  - Subsequent ticks occur every De cycles.
- One-shot: busy falls at edge E0+De.
- Square: first rising edge of sq_out at E0+(De>>1), or at E0 itself when De=1.
- No dead cycles: back-to-back writes on consecutive cycles are each accepted.

## Test plan
- Reset, then write ch0 mode=01 div=4 -> tick[0] high one cycle at E0+3, E0+7, E0+11; busy[0]=1; other channels all outputs 0.
- Write ch1 mode=10 div=5 -> sq_out[1] repeating pattern 0,0,1,1,1; write div=1 -> constant 1; write div=0 -> constant 1.
- Write ch2 mode=11 div=3 -> single tick[2] at E0+2, busy[2] falls at E0+3, no further ticks over 20 cycles. A re-write at E0+1 with div=6 -> only one tick, at (E0+1)+5.
- ch0 div=10 and ch3 div=10 started 3 cycles apart, then sync pulse -> both tick on the same cycle 9 edges after sync, persisting; ch1 in mode 00 remains off.
- Write cfg_ch=N_CH (out of range) -> no state change on any channel. Assert rst mid one-shot -> all outputs 0 the next cycle, no pulse afterwards.
- Write mode=01 div=2^WIDTH-1 with WIDTH=4 -> tick period 15, wrap 14->0 with no overflow.
